booth_r4_seq_mult: RTL and testbench

- Iterative signed radix-4 Booth multiplier core that sits directly downstream of the Booth recoding unit.
- Scans the latched multiplier two bits per cycle and presents each 3-bit window on `xi` to an external combinational recoder.
- Consumes the recoder's `op`/`sign` in the same cycle and accumulates the selected partial product (0, ±A, ±2A).
- Delivers a 2N-bit two's-complement product with a start/busy/done handshake.

---
 rtl/booth_r4_seq_mult.sv | 111 +++++++++++
 tb/tb_booth_r4_seq_mult.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier.
// Walks the multiplier two bits per cycle and accumulates the recoded partial products.
`timescale 1ns/1ps
module booth_r4_seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2:0]     xi,
  input  logic [1:0]     op,
  input  logic           sign,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int W  = 2*N + 2;
  localparam int CW = $clog2(N/2) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, nstate;
  logic [N-1:0]  areg;
  logic [N:0]    mreg;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  aext;
  logic [W-1:0]  mag;
  logic [W-1:0]  pp;
  logic [W-1:0]  acc_nxt;
  logic          last;
  logic          accept;

  assign last = (cnt == CW'(N/2 - 1));

  // next state and handshake outputs
  always_comb begin
    nstate = state;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          nstate = RUN;
        end
      end
      RUN: begin
        if (last) nstate = DONE;
      end
      DONE: begin
        if (start) begin
          accept = 1'b1;
          nstate = RUN;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign xi   = (state == RUN) ? mreg[2:0] : 3'b000;

  // partial product select; op=3 falls to zero
  always_comb begin
    aext = {{(N+2){areg[N-1]}}, areg};
    mag  = '0;
    unique case (1'b1)
      (op == 2'd1): mag = aext;
      (op == 2'd2): mag = aext << 1;
      default:      mag = '0;
    endcase
    pp      = sign ? (~mag + 1'b1) : mag;
    acc_nxt = acc + (pp << {cnt, 1'b0});
  end

  // state, operand and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      areg    <= '0;
      mreg    <= '0;
      cnt     <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        areg <= a;
        mreg <= {b, 1'b0};
        cnt  <= '0;
        acc  <= '0;
      end else if (state == RUN) begin
        acc  <= acc_nxt;
        mreg <= mreg >> 2;
        cnt  <= cnt + 1'b1;
        if (last) product <= acc_nxt[2*N-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult.
// Directed cases plus random operands against plain signed multiplication.
`timescale 1ns/1ps
module tb_booth_r4_seq_mult;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic [2:0]  xi;
  logic [1:0]  op;
  logic        sign;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int   total = 0;
  int   bad   = 0;
  logic drop_now = 1'b0;

  always #5 clk = ~clk;

  booth_r4_seq_mult #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .xi(xi), .op(op), .sign(sign),
    .busy(busy), .done(done), .product(product)
  );

  // external Booth recoder, with an override that injects op=3
  always_comb begin
    op   = 2'd0;
    sign = 1'b0;
    case (xi)
      3'b001, 3'b010: begin op = 2'd1; sign = 1'b0; end
      3'b011:         begin op = 2'd2; sign = 1'b0; end
      3'b100:         begin op = 2'd2; sign = 1'b1; end
      3'b101, 3'b110: begin op = 2'd1; sign = 1'b1; end
      default:        begin op = 2'd0; sign = xi[2]; end
    endcase
    if (drop_now) begin
      op   = 2'd3;
      sign = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2:0] win(input logic [7:0] bv, input int i);
    logic [8:0] e;
    e = {bv, 1'b0};
    return {e[2*i+2], e[2*i+1], e[2*i]};
  endfunction

  function automatic int digit(input logic [7:0] bv, input int i);
    int d;
    d = -2 * int'(bv[2*i+1]) + int'(bv[2*i]);
    if (i > 0) d += int'(bv[2*i-1]);
    return d;
  endfunction

  function automatic logic [15:0] model(input logic [7:0] av,
                                       input logic [7:0] bv, input int dk);
    int sa, sb, p;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    p  = sa * sb;
    if (dk >= 0) p -= sa * digit(bv, dk) * (1 << (2*dk));
    return p[15:0];
  endfunction

  task automatic mul(input logic [7:0] av, input logic [7:0] bv,
                     input int dk, input bit full);
    logic [15:0] prev;
    prev  = product;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    for (int j = 0; j < N/2; j++) begin
      chk("xi", {29'd0, xi}, {29'd0, win(bv, j)});
      if (full) begin
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_done", {31'd0, done}, 32'd0);
      end
      if (j == 0) chk("run_hold", {16'd0, product}, {16'd0, prev});
      drop_now = (j == dk);
      tick;
    end
    drop_now = 1'b0;
    chk("done", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("product", {16'd0, product}, {16'd0, model(av, bv, dk)});
  endtask

  initial begin
    logic [7:0] ra, rb;
    int dk;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_prod", {16'd0, product}, 32'd0);
    chk("rst_xi", {29'd0, xi}, 32'd0);

    mul(8'd7, 8'd3, -1, 1'b1);
    chk("p_7x3", {16'd0, product}, 32'h0015);
    tick;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_xi", {29'd0, xi}, 32'd0);

    mul(8'h80, 8'h80, -1, 1'b1);
    chk("p_min_min", {16'd0, product}, 32'h4000);
    tick;
    tick;
    chk("hold1", {16'd0, product}, 32'h4000);
    mul(8'h80, 8'h7f, -1, 1'b1);
    chk("p_min_max", {16'd0, product}, 32'hc080);
    tick;
    mul(8'h00, 8'hff, -1, 1'b1);
    chk("p_0xm1", {16'd0, product}, 32'h0000);
    tick;

    a     = 8'hfb;
    b     = 8'h06;
    start = 1'b1;
    tick;
    a = 8'h09;
    b = 8'hf7;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5 || c == 10) begin
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_busy", {31'd0, busy}, 32'd0);
        chk("b2b_prod", {16'd0, product},
            (c == 5) ? 32'hffe2 : 32'hffaf);
      end else begin
        chk("b2b_run_done", {31'd0, done}, 32'd0);
        chk("b2b_run_busy", {31'd0, busy}, 32'd1);
      end
      if (c == 10) start = 1'b0;
      tick;
    end
    chk("b2b_end_done", {31'd0, done}, 32'd0);
    chk("b2b_end_busy", {31'd0, busy}, 32'd0);
    chk("b2b_hold", {16'd0, product}, 32'hffaf);

    a     = 8'd3;
    b     = 8'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    a     = 8'd100;
    b     = 8'd100;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("ign_early", {31'd0, done}, 32'd0);
    tick;
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_prod", {16'd0, product}, 32'h000f);
    tick;
    chk("ign_no_extra", {31'd0, done}, 32'd0);
    tick;
    chk("ign_no_extra2", {31'd0, done}, 32'd0);
    chk("ign_idle", {31'd0, busy}, 32'd0);

    a     = 8'd7;
    b     = 8'd9;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_prod", {16'd0, product}, 32'd0);
    chk("mrst_xi", {29'd0, xi}, 32'd0);
    tick;
    chk("mrst_stays", {31'd0, done}, 32'd0);
    mul(8'd4, 8'd4, -1, 1'b1);
    chk("p_4x4", {16'd0, product}, 32'h0010);
    tick;

    mul(8'd7, 8'd3, 0, 1'b1);
    chk("drop0", {16'd0, product}, 32'h001c);
    tick;

    for (int k = 0; k < 2000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      dk = ($urandom_range(15) == 0) ? int'($urandom_range(3)) : -1;
      mul(ra, rb, dk, 1'b0);
      if ($urandom_range(1) == 1) tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
